gemm_tiler: RTL and testbench
=============================

# gemm_tiler

Job-level front end for `control_unit`. Accepts one GEMM job (D = A·B + C, arbitrary M/K/N up to 255) and decomposes it into 16×16 tile commands. It drives `control_unit`'s `cmd_valid/cmd_data/cmd_ready` port and tracks completion through `done_irq`. It serialises K-accumulation chains so that every partial-sum tile is written back before it is re-read as bias.

## Interface
- `ADDR_WIDTH`, 10, buffer address width; 4·ADDR_WIDTH+24 must equal 64, otherwise elaboration error.
- `SYSTOLIC_ARRAY_WIDTH` (W), 16, tile edge; also the address stride per tile.
- `DIM_WIDTH`, 8, width of job dimensions.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  high only in IDLE.
- `job_m`, `job_k`, `job_n`  in  DIM_WIDTH  matrix dimensions.
- `job_addr_a`, `job_addr_b`, `job_addr_c`, `job_addr_d`  in  ADDR_WIDTH  base addresses.
- `cmd_valid`  out  1  tile command valid.
- `cmd_data`  out  64  packed command: [63:54] addr_d, [53:44] addr_c, [43:34] addr_b, [33:24] addr_a, [23:16] len_n, [15:8] len_k, [7:0] len_m.
- `cmd_ready`  in  1  `control_unit` FIFO not full.
- `done_irq`  in  1  one-cycle pulse per completed tile writeback.
- `busy`  out  1  state ≠ IDLE.
- `job_done`  out  1  one-cycle pulse: job finished.
- `job_err`  out  1  one-cycle pulse with `job_done`: zero dimension.

## Operation
- Job fields are latched on `job_valid && job_ready`.
- Tile counts: MT = ceil(M/W), KT = ceil(K/W), NT = ceil(N/W), each in 1..16.
- Issue order: m outer, n middle, k inner.
- Tile lengths:
  - len_m = W, except the last m tile, where len_m = M − W·(MT−1).
  - len_k and len_n follow the same rule.
- Tile addresses, all mod 2^ADDR_WIDTH:
  - A = base_a + W·(m·KT+k)
  - B = base_b + W·(k·NT+n)
  - D = base_d + W·(m·NT+n)
  - C = base_c + W·(m·NT+n) when k=0; C = D (same tile) when k>0.
- Outstanding counter (5 bits):
  - +1 on `cmd_valid && cmd_ready`.
  - −1 on `done_irq`.
  - Both in the same cycle: unchanged.
  - `done_irq` while the counter is 0 is ignored; the counter does not underflow.
- State machine:
  - IDLE: `job_ready` high. On accept, go to ERR if any dimension is 0, else ISSUE.
  - ERR: pulse `job_done` and `job_err`, then go to IDLE.
  - ISSUE: `cmd_valid` high with the current tile. On handshake, advance the indices.
    - If tiles remain and the next tile has k>0, go to WAIT_DEP.
    - If tiles remain and the next tile has k=0, stay in ISSUE.
    - If no tiles remain, go to DRAIN.
  - WAIT_DEP: `cmd_valid` low. When outstanding == 0, or outstanding == 1 with `done_irq` high, go to ISSUE.
  - DRAIN: same completion condition as WAIT_DEP. On that condition, pulse `job_done` and go to IDLE.
- Reset at any time:
  - State returns to IDLE, indices and counter clear, all outputs take their reset values.
  - `done_irq` pulses from commands issued before reset are absorbed by the no-underflow rule.

## Timing
- Reset values: `job_ready`=1, `cmd_valid`=0, `cmd_data`=0, `busy`=0, `job_done`=0, `job_err`=0.
- First `cmd_valid` is asserted the cycle after job accept.
- `cmd_valid`/`cmd_data` are registered and held stable until `cmd_ready` is sampled high.
  - Never deassert `cmd_valid` without a handshake.
- Consecutive k=0 tiles issue back-to-back: one command per cycle while `cmd_ready` is high.
- A k>0 tile enters ISSUE the cycle after its dependency condition holds.
- `job_done` is asserted the cycle after the last `done_irq`. `busy` falls on the same edge.
- `job_ready` goes high again the cycle after `job_done`.
- A new job presented during `job_done` is not accepted until the following cycle.

## Test plan
- M=K=N=16, bases A=0x000, B=0x100, C=0x200, D=0x300:
  - expect one command {D=0x300, C=0x200, B=0x100, A=0x000, len 16/16/16}.
  - after `done_irq`, `job_done` pulses once and `job_err` stays 0.
- M=20, K=16, N=16, same bases:
  - expect 2 back-to-back commands: A=0x000 then A=0x010; D=0x300 then 0x310; C=0x200 then 0x210.
  - len_m is 16 then 4.
- M=16, K=40, N=16:
  - expect 3 commands: len_k 16, 16, 8; B=0x100, 0x110, 0x120.
  - 2nd and 3rd commands have C=0x300 (equal to D).
  - each is issued only after the prior `done_irq`, measured as ≥1 cycle gap.
- Backpressure: hold `cmd_ready`=0 for 5 cycles in the M=20 job.
  - `cmd_valid` and `cmd_data` stay constant throughout.
  - exactly 2 handshakes occur.
- job_k=0:
  - `job_done` and `job_err` pulse together.
  - no `cmd_valid`; `job_ready` returns the next cycle.
- Assert `rst` between the 1st and 2nd command of the K=40 job, then send a stray `done_irq` after reset.
  - all outputs are at reset values.
  - the outstanding counter stays 0.
  - a following 16³ job completes normally.

Source files
------------

// File: rtl/gemm_tiler.sv
// gemm_tiler: splits one GEMM job into 16x16 tile commands and serialises each K-accumulation chain
module gemm_tiler #(
   parameter int ADDR_WIDTH           = 10,
   parameter int SYSTOLIC_ARRAY_WIDTH = 16,
   parameter int DIM_WIDTH            = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [DIM_WIDTH-1:0]  job_m,
   input  logic [DIM_WIDTH-1:0]  job_k,
   input  logic [DIM_WIDTH-1:0]  job_n,
   input  logic [ADDR_WIDTH-1:0] job_addr_a,
   input  logic [ADDR_WIDTH-1:0] job_addr_b,
   input  logic [ADDR_WIDTH-1:0] job_addr_c,
   input  logic [ADDR_WIDTH-1:0] job_addr_d,
   output logic                  cmd_valid,
   output logic [63:0]           cmd_data,
   input  logic                  cmd_ready,
   input  logic                  done_irq,
   output logic                  busy,
   output logic                  job_done,
   output logic                  job_err
);
   localparam int W  = SYSTOLIC_ARRAY_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam int DW = DIM_WIDTH;
   localparam int CW = DIM_WIDTH + 1;

   if (4 * ADDR_WIDTH + 24 != 64) begin : g_bad_addr_width
      $error("gemm_tiler: 4*ADDR_WIDTH+24 must equal 64");
   end

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DEP, DRAIN, ERR} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   m_q, m_d, k_q, k_d, n_q, n_d;
   logic [CW-1:0]   mt_q, mt_d, kt_q, kt_d, nt_q, nt_d;
   logic [CW-1:0]   mi_q, mi_d, ki_q, ki_d, ni_q, ni_d;
   logic [AW-1:0]   ba_q, ba_d, bb_q, bb_d, bc_q, bc_d, bd_q, bd_d;
   logic [4:0]      outst_q, outst_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [63:0]     cmd_data_q, cmd_data_d;
   logic            job_done_q, job_done_d;
   logic            job_err_q, job_err_d;
   logic            hs, dep_clear, zero_dim;

   function automatic logic [CW-1:0] tiles(input logic [DW-1:0] x);
      return CW'((int'(x) + W - 1) / W);
   endfunction

   function automatic logic [63:0] tile_cmd(
      input logic [DW-1:0] dm, dk, dn,
      input logic [CW-1:0] mt, kt, nt, mi, ki, ni,
      input logic [AW-1:0] ba, bb, bc, bd
   );
      int lm, lk, ln, a, b, c, d;
      lm = (mi == mt - 1'b1) ? int'(dm) - W * (int'(mt) - 1) : W;
      lk = (ki == kt - 1'b1) ? int'(dk) - W * (int'(kt) - 1) : W;
      ln = (ni == nt - 1'b1) ? int'(dn) - W * (int'(nt) - 1) : W;
      a  = int'(ba) + W * (int'(mi) * int'(kt) + int'(ki));
      b  = int'(bb) + W * (int'(ki) * int'(nt) + int'(ni));
      d  = int'(bd) + W * (int'(mi) * int'(nt) + int'(ni));
      c  = (ki == '0) ? int'(bc) + W * (int'(mi) * int'(nt) + int'(ni)) : d;
      return {AW'(d), AW'(c), AW'(b), AW'(a), 8'(ln), 8'(lk), 8'(lm)};
   endfunction

   assign job_ready = (state_q == IDLE) && !job_done_q;
   assign busy      = state_q != IDLE;
   assign cmd_valid = cmd_valid_q;
   assign cmd_data  = cmd_data_q;
   assign job_done  = job_done_q;
   assign job_err   = job_err_q;

   // next-state, tile index walk, command build and outstanding tracking
   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      k_d         = k_q;
      n_d         = n_q;
      mt_d        = mt_q;
      kt_d        = kt_q;
      nt_d        = nt_q;
      mi_d        = mi_q;
      ki_d        = ki_q;
      ni_d        = ni_q;
      ba_d        = ba_q;
      bb_d        = bb_q;
      bc_d        = bc_q;
      bd_d        = bd_q;
      cmd_valid_d = cmd_valid_q;
      job_done_d  = 1'b0;
      job_err_d   = 1'b0;
      hs          = cmd_valid_q && cmd_ready;
      dep_clear   = (outst_q == 5'd0) || (outst_q == 5'd1 && done_irq);
      zero_dim    = (job_m == '0) || (job_k == '0) || (job_n == '0);
      case (state_q)
         IDLE: if (job_valid && job_ready) begin
            m_d         = job_m;
            k_d         = job_k;
            n_d         = job_n;
            mt_d        = tiles(job_m);
            kt_d        = tiles(job_k);
            nt_d        = tiles(job_n);
            mi_d        = '0;
            ki_d        = '0;
            ni_d        = '0;
            ba_d        = job_addr_a;
            bb_d        = job_addr_b;
            bc_d        = job_addr_c;
            bd_d        = job_addr_d;
            state_d     = zero_dim ? ERR : ISSUE;
            cmd_valid_d = !zero_dim;
         end
         ISSUE: if (hs) begin
            if (ki_q + 1'b1 < kt_q) begin
               ki_d        = ki_q + 1'b1;
               state_d     = WAIT_DEP;
               cmd_valid_d = 1'b0;
            end else if (ni_q + 1'b1 < nt_q) begin
               ki_d = '0;
               ni_d = ni_q + 1'b1;
            end else if (mi_q + 1'b1 < mt_q) begin
               ki_d = '0;
               ni_d = '0;
               mi_d = mi_q + 1'b1;
            end else begin
               state_d     = DRAIN;
               cmd_valid_d = 1'b0;
            end
         end
         WAIT_DEP: if (dep_clear) begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
         end
         DRAIN: if (dep_clear) begin
            state_d    = IDLE;
            job_done_d = 1'b1;
         end
         ERR: begin
            state_d    = IDLE;
            job_done_d = 1'b1;
            job_err_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      cmd_data_d = cmd_valid_d ? tile_cmd(m_d, k_d, n_d, mt_d, kt_d, nt_d, mi_d, ki_d, ni_d,
                                          ba_d, bb_d, bc_d, bd_d) : cmd_data_q;
      outst_d    = outst_q + 5'(hs) - 5'(done_irq && outst_q != 5'd0);
   end

   // state and datapath registers; reset clears indices, counter and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         m_q         <= '0;
         k_q         <= '0;
         n_q         <= '0;
         mt_q        <= '0;
         kt_q        <= '0;
         nt_q        <= '0;
         mi_q        <= '0;
         ki_q        <= '0;
         ni_q        <= '0;
         ba_q        <= '0;
         bb_q        <= '0;
         bc_q        <= '0;
         bd_q        <= '0;
         outst_q     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         job_done_q  <= 1'b0;
         job_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         k_q         <= k_d;
         n_q         <= n_d;
         mt_q        <= mt_d;
         kt_q        <= kt_d;
         nt_q        <= nt_d;
         mi_q        <= mi_d;
         ki_q        <= ki_d;
         ni_q        <= ni_d;
         ba_q        <= ba_d;
         bb_q        <= bb_d;
         bc_q        <= bc_d;
         bd_q        <= bd_d;
         outst_q     <= outst_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_data_q  <= cmd_data_d;
         job_done_q  <= job_done_d;
         job_err_q   <= job_err_d;
      end
   end
endmodule

// File: tb/tb_gemm_tiler.sv
// tb_gemm_tiler: directed job table plus backpressure and mid-job reset sequences
module tb_gemm_tiler;
   logic        clk, rst, job_valid, job_ready, cmd_valid, cmd_ready, done_irq, busy, job_done, job_err;
   logic [7:0]  job_m, job_k, job_n;
   logic [9:0]  job_addr_a, job_addr_b, job_addr_c, job_addr_d;
   logic [63:0] cmd_data;
   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0]       m, k, n;
      int               ncmd;
      int               gap;
      logic             err;
      logic [2:0][63:0] cmd;
   } vec_t;

   vec_t tbl[5];

   gemm_tiler dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .job_m(job_m), .job_k(job_k), .job_n(job_n),
      .job_addr_a(job_addr_a), .job_addr_b(job_addr_b), .job_addr_c(job_addr_c), .job_addr_d(job_addr_d),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .done_irq(done_irq),
      .busy(busy), .job_done(job_done), .job_err(job_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input logic [9:0] d, c, b, a, input logic [7:0] ln, lk, lm);
      return {d, c, b, a, ln, lk, lm};
   endfunction

   function automatic vec_t mk(input logic [7:0] m, k, n, input int ncmd, gap, input logic err,
                               input logic [63:0] c0, c1, c2);
      vec_t v;
      v.m = m; v.k = k; v.n = n; v.ncmd = ncmd; v.gap = gap; v.err = err;
      v.cmd[0] = c0; v.cmd[1] = c1; v.cmd[2] = c2;
      return v;
   endfunction

   // accept one job, respond to each command with done_irq 3 cycles later, check commands and completion
   task automatic run_job(input vec_t v, input int stall);
      int hs = 0;
      int last_hs = -100;
      int last_done = -100;
      bit done_seen = 0;
      int due[$];
      job_m = v.m; job_k = v.k; job_n = v.n; job_valid = 1'b1; cmd_ready = (stall == 0);
      chk("job_ready_at_accept", 64'(job_ready), 64'd1);
      @(posedge clk); #1;
      job_valid = 1'b0;
      for (int t = 0; t < 300 && !done_seen; t++) begin
         if (t < stall) begin
            chk("stall_valid", 64'(cmd_valid), 64'd1);
            chk("stall_data", cmd_data, v.cmd[0]);
         end
         if (t == stall) cmd_ready = 1'b1;
         if (cmd_valid && cmd_ready) begin
            if (hs < v.ncmd) chk($sformatf("cmd%0d_data", hs), cmd_data, v.cmd[hs]);
            else chk("extra_cmd", 64'(hs), 64'(v.ncmd));
            if (hs > 0) chk($sformatf("cmd%0d_gap", hs), 64'(t - last_hs), 64'(v.gap));
            last_hs = t;
            hs++;
            due.push_back(t + 3);
         end
         if (job_done) begin
            done_seen = 1;
            chk("job_err", 64'(job_err), 64'(v.err));
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("ready_at_done", 64'(job_ready), 64'd0);
            if (v.ncmd > 0) chk("done_latency", 64'(t - last_done), 64'd1);
         end
         done_irq = (due.size() > 0 && due[0] == t);
         if (done_irq) begin
            void'(due.pop_front());
            last_done = t;
         end
         @(posedge clk); #1;
      end
      done_irq = 1'b0;
      chk("job_done_seen", 64'(done_seen), 64'd1);
      chk("handshake_count", 64'(hs), 64'(v.ncmd));
      chk("ready_after_done", 64'(job_ready), 64'd1);
      chk("done_one_pulse", 64'(job_done), 64'd0);
   endtask

   initial begin
      rst = 1'b1; job_valid = 1'b0; cmd_ready = 1'b1; done_irq = 1'b0;
      job_m = '0; job_k = '0; job_n = '0;
      job_addr_a = 10'h000; job_addr_b = 10'h100; job_addr_c = 10'h200; job_addr_d = 10'h300;
      tbl[0] = mk(16, 16, 16, 1, 1, 0, pk(10'h300, 10'h200, 10'h100, 10'h000, 16, 16, 16), '0, '0);
      tbl[1] = mk(20, 16, 16, 2, 1, 0, pk(10'h300, 10'h200, 10'h100, 10'h000, 16, 16, 16),
                  pk(10'h310, 10'h210, 10'h100, 10'h010, 16, 16, 4), '0);
      tbl[2] = mk(16, 40, 16, 3, 4, 0, pk(10'h300, 10'h200, 10'h100, 10'h000, 16, 16, 16),
                  pk(10'h300, 10'h300, 10'h110, 10'h010, 16, 16, 16),
                  pk(10'h300, 10'h300, 10'h120, 10'h020, 16, 8, 16));
      tbl[3] = mk(16, 16, 20, 2, 1, 0, pk(10'h300, 10'h200, 10'h100, 10'h000, 16, 16, 16),
                  pk(10'h310, 10'h210, 10'h110, 10'h000, 4, 16, 16), '0);
      tbl[4] = mk(16, 0, 16, 0, 1, 1, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_job_ready", 64'(job_ready), 64'd1);
      chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("rst_cmd_data", cmd_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_job_done", 64'(job_done), 64'd0);
      chk("rst_job_err", 64'(job_err), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) run_job(tbl[i], 0);
      run_job(tbl[1], 5);
      job_m = 16; job_k = 40; job_n = 16; job_valid = 1'b1; cmd_ready = 1'b1;
      @(posedge clk); #1;
      job_valid = 1'b0;
      chk("k40_first_valid", 64'(cmd_valid), 64'd1);
      @(posedge clk); #1;
      chk("k40_wait_dep", 64'(cmd_valid), 64'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_job_ready", 64'(job_ready), 64'd1);
      chk("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("mid_rst_cmd_data", cmd_data, 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_job_done", 64'(job_done), 64'd0);
      chk("mid_rst_job_err", 64'(job_err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      done_irq = 1'b1;
      @(posedge clk); #1;
      done_irq = 1'b0;
      chk("stray_irq_outstanding", 64'(dut.outst_q), 64'd0);
      chk("stray_irq_busy", 64'(busy), 64'd0);
      run_job(tbl[0], 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
